// File: rtl/fft_frame_scheduler.sv
// Frame sequencer ahead of the 32-point FFT core: buffers one frame, replays it as a
// gap-free burst, then tags core outputs with bin indices. Optional macro: FFT_TIMEOUT_EN.
module fft_frame_scheduler #(
    parameter int FFT_SIZE      = 32,
    parameter int IN_WIDTH      = 12,
    parameter int OUT_WIDTH     = 16,
    parameter int LATENCY_LIMIT = 68,
    localparam int CNT_W        = $clog2(FFT_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [IN_WIDTH-1:0]  s_din_r,
    input  logic signed [IN_WIDTH-1:0]  s_din_i,
    output logic                        fft_in_valid,
    output logic signed [IN_WIDTH-1:0]  fft_din_r,
    output logic signed [IN_WIDTH-1:0]  fft_din_i,
    input  logic                        fft_out_valid,
    input  logic signed [OUT_WIDTH-1:0] fft_dout_r,
    input  logic signed [OUT_WIDTH-1:0] fft_dout_i,
    output logic                        m_valid,
    output logic signed [OUT_WIDTH-1:0] m_dout_r,
    output logic signed [OUT_WIDTH-1:0] m_dout_i,
    output logic [CNT_W-1:0]            m_index,
    output logic                        m_last,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        err_timeout,
    input  logic                        clr_err
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);

    typedef enum logic [1:0] {FILL, BURST, WAIT, OUT} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0]      wr_cnt_reg, burst_cnt_reg, rd_cnt_reg;
    logic [2*IN_WIDTH-1:0] frame_mem [FFT_SIZE];
    logic accept, last_accept, beat, burst_done, capture, last_capture, abort;

`ifdef FFT_TIMEOUT_EN
    localparam int LAT_W = $clog2(LATENCY_LIMIT + 1);
    logic [LAT_W-1:0] lat_cnt_reg;
`endif

    always_comb begin
        state_next   = state_reg;
        s_ready      = 1'b0;
        accept       = 1'b0;
        last_accept  = 1'b0;
        beat         = 1'b0;
        burst_done   = 1'b0;
        capture      = 1'b0;
        last_capture = 1'b0;
        abort        = 1'b0;
        case (state_reg)
            FILL: begin
                s_ready     = 1'b1;
                accept      = s_valid;
                last_accept = s_valid && (wr_cnt_reg == LAST_IDX);
                // beat 0 is launched on the same edge that stores the final sample
                beat        = last_accept;
                if (last_accept) state_next = BURST;
            end
            BURST: begin
                // burst_cnt wraps back to 0 once every beat has been launched
                if (burst_cnt_reg == '0) begin
                    burst_done = 1'b1;
                    state_next = WAIT;
                end else begin
                    beat = 1'b1;
                end
            end
            WAIT, OUT: begin
                capture      = fft_out_valid;
                last_capture = fft_out_valid && (rd_cnt_reg == LAST_IDX);
                if (last_capture)  state_next = FILL;
                else if (capture)  state_next = OUT;
`ifdef FFT_TIMEOUT_EN
                if ((lat_cnt_reg == LAT_W'(LATENCY_LIMIT)) && !last_capture) begin
                    abort      = 1'b1;
                    capture    = 1'b0;
                    state_next = FILL;
                end
`endif
            end
            default: state_next = FILL;
        endcase
    end

    assign busy = (state_reg != FILL);

    always_ff @(posedge clk) begin
        if (accept) frame_mem[wr_cnt_reg] <= {s_din_r, s_din_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FILL;
            wr_cnt_reg    <= '0;
            burst_cnt_reg <= '0;
            rd_cnt_reg    <= '0;
            fft_in_valid  <= 1'b0;
            fft_din_r     <= '0;
            fft_din_i     <= '0;
            m_valid       <= 1'b0;
            m_dout_r      <= '0;
            m_dout_i      <= '0;
            m_index       <= '0;
            m_last        <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            m_valid    <= capture;
            m_last     <= last_capture;
            frame_done <= m_last;
            if (accept) wr_cnt_reg <= wr_cnt_reg + 1'b1;
            if (beat) begin
                fft_in_valid             <= 1'b1;
                {fft_din_r, fft_din_i}   <= frame_mem[burst_cnt_reg];
                burst_cnt_reg            <= burst_cnt_reg + 1'b1;
            end else if (burst_done) begin
                fft_in_valid <= 1'b0;
            end
            if (capture) begin
                m_dout_r   <= fft_dout_r;
                m_dout_i   <= fft_dout_i;
                m_index    <= rd_cnt_reg;
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end else if (abort) begin
                rd_cnt_reg <= '0;
            end
        end
    end

`ifdef FFT_TIMEOUT_EN
    // lat_cnt stops advancing on its own: reaching the limit always leaves WAIT/OUT
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_reg <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (burst_done)
                lat_cnt_reg <= '0;
            else if (state_reg == WAIT || state_reg == OUT)
                lat_cnt_reg <= lat_cnt_reg + 1'b1;
            if (abort)
                err_timeout <= 1'b1;
            else if (clr_err)
                err_timeout <= 1'b0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok   = clr_err | (LATENCY_LIMIT == 0);
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with a behavioural FFT core stub
// (programmable latency, gap and output count).
module tb_fft_frame_scheduler;
    localparam int N   = 32;
    localparam int IW  = 12;
    localparam int OW  = 16;
    localparam int LIM = 68;

    logic clk = 1'b0;
    logic reset, s_valid, s_ready, clr_err;
    logic [IW-1:0] s_din_r, s_din_i, fft_din_r, fft_din_i;
    logic fft_in_valid, fft_out_valid;
    logic [OW-1:0] fft_dout_r, fft_dout_i, m_dout_r, m_dout_i;
    logic m_valid, m_last, busy, frame_done, err_timeout;
    logic [4:0] m_index;

    fft_frame_scheduler dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_din_r(s_din_r), .s_din_i(s_din_i),
        .fft_in_valid(fft_in_valid), .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
        .fft_out_valid(fft_out_valid), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
        .m_valid(m_valid), .m_dout_r(m_dout_r), .m_dout_i(m_dout_i),
        .m_index(m_index), .m_last(m_last), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic [IW-1:0] r; logic [IW-1:0] i;} smp_t;
    typedef struct {logic [OW-1:0] r; logic [OW-1:0] i; logic [4:0] idx; logic last; int cyc;} mexp_t;

    smp_t  exp_burst[$];
    mexp_t exp_m[$];

    int checks = 0, errors = 0;
    int run_len = 0, bursts_seen = 0, frames_done = 0;
    int last_acc_cyc = 0, burst_end_cyc = 0;
    bit rst_abort = 1'b0;
    bit prev_last = 1'b0;

    // stub configuration, latched by the stub at the start of each frame
    int stub_lat = 5, stub_cnt = N, stub_gap_at = -5, stub_gap_len = 0;
    int stray_n = 0, stray_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // monitor: burst beats, result samples and frame_done pulses
    smp_t  eb;
    mexp_t em;
    always @(negedge clk) begin
        if (fft_in_valid === 1'b1) begin
            if (run_len == 0) check("burst_start_cycle", 32'(cyc), 32'(last_acc_cyc + 1));
            if (exp_burst.size() == 0) fail_now("burst_unexpected_beat");
            else begin
                eb = exp_burst.pop_front();
                check("fft_din_r", 32'(fft_din_r), 32'(eb.r));
                check("fft_din_i", 32'(fft_din_i), 32'(eb.i));
            end
            run_len++;
        end else if (run_len != 0) begin
            if (rst_abort) begin
                exp_burst.delete();
                rst_abort = 1'b0;
            end else begin
                check("burst_length", 32'(run_len), 32'(N));
                burst_end_cyc = cyc;
                bursts_seen++;
            end
            run_len = 0;
        end

        if (m_valid === 1'b1) begin
            if (exp_m.size() == 0) fail_now("m_valid_unexpected");
            else begin
                em = exp_m.pop_front();
                check("m_dout_r", 32'(m_dout_r), 32'(em.r));
                check("m_dout_i", 32'(m_dout_i), 32'(em.i));
                check("m_index", 32'(m_index), 32'(em.idx));
                check("m_last", 32'(m_last), 32'(em.last));
                check("m_valid_cycle", 32'(cyc), 32'(em.cyc));
            end
        end else if (m_last === 1'b1) begin
            fail_now("m_last_without_m_valid");
        end

        if (frame_done === 1'b1) begin
            check("frame_done_after_last", 32'(prev_last), 32'd1);
            check("s_ready_after_frame", 32'(s_ready), 32'd1);
            frames_done++;
            $display("frame %0d complete at cycle %0d", frames_done, cyc);
        end
        prev_last = (m_valid === 1'b1) && (m_last === 1'b1);
    end

    // behavioural FFT core: answers each completed burst with programmable timing
    initial begin : core_stub
        int served = 0;
        int lat, cnt, gat, glen, sn, sd;
        mexp_t me;
        fft_out_valid = 1'b0;
        fft_dout_r    = '0;
        fft_dout_i    = '0;
        forever begin
            wait (bursts_seen > served);
            served++;
            lat = stub_lat; cnt = stub_cnt; gat = stub_gap_at; glen = stub_gap_len;
            sn = stray_n; sd = stray_delay;
            repeat (lat) @(negedge clk);
            for (int k = 0; k < cnt; k++) begin
                if (k == gat + 1) begin
                    fft_out_valid = 1'b0;
                    repeat (glen) @(negedge clk);
                end
                fft_out_valid = 1'b1;
                fft_dout_r    = OW'($urandom);
                fft_dout_i    = OW'($urandom);
                me.r = fft_dout_r; me.i = fft_dout_i; me.idx = 5'(k);
                me.last = (k == N - 1); me.cyc = cyc + 1;
                exp_m.push_back(me);
                @(negedge clk);
            end
            fft_out_valid = 1'b0;
            repeat (sd) @(negedge clk);
            for (int k = 0; k < sn; k++) begin
                fft_out_valid = 1'b1;
                fft_dout_r    = OW'($urandom);
                fft_dout_i    = OW'($urandom);
                @(negedge clk);
            end
            fft_out_valid = 1'b0;
        end
    end

    // gap_mode: 0 contiguous, 1 valid every 3rd cycle, 2 random gaps
    task automatic send_frame(input int gap_mode, input bit ramp);
        smp_t f[N];
        int j, budget;
        for (int k = 0; k < N; k++) begin
            f[k].r = ramp ? IW'(k)  : IW'($urandom);
            f[k].i = ramp ? IW'(-k) : IW'($urandom);
        end
        j = 0;
        budget = 0;
        while (j < N && budget < 3000) begin
            @(negedge clk);
            budget++;
            if ((gap_mode == 1 && (cyc % 3) != 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_din_r = f[j].r;
                s_din_i = f[j].i;
                if (s_ready === 1'b1) begin
                    exp_burst.push_back(f[j]);
                    if (j == N - 1) last_acc_cyc = cyc;
                    j++;
                end
            end
        end
        if (j < N) fail_now("send_frame_timeout");
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_count", 32'(frames_done), 32'(n));
        check("result_queue_drained", 32'(exp_m.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nf, t, bad, b0;
        reset = 1'b1; s_valid = 1'b0; s_din_r = '0; s_din_i = '0; clr_err = 1'b0;
        nf = 0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fft_in_valid", 32'(fft_in_valid), 32'd0);
        check("rst_fft_din_r", 32'(fft_din_r), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_dout_r", 32'(m_dout_r), 32'd0);
        check("rst_m_index", 32'(m_index), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        reset = 1'b0;

        // 1: contiguous ramp frame
        stub_lat = 8; stub_gap_len = 0; stray_n = 0;
        send_frame(0, 1'b1);
        nf++; wait_frames(nf, 400);

        // 2: source valid every 3rd cycle; stray core outputs afterwards in FILL
        stub_lat = $urandom_range(1, 10); stub_gap_at = $urandom_range(0, 30);
        stub_gap_len = $urandom_range(0, 5); stray_n = 3; stray_delay = 2;
        send_frame(1, 1'b0);
        nf++; wait_frames(nf, 500);

        // 3: latency 20 with a 4-cycle gap after bin 15
        stub_lat = 20; stub_gap_at = 15; stub_gap_len = 4; stray_n = 0;
        send_frame(2, 1'b0);
        nf++; wait_frames(nf, 500);
        check("s_ready_idle", 32'(s_ready), 32'd1);

`ifdef FFT_TIMEOUT_EN
        // 4: core returns only 10 outputs, then strays long after the abort
        stub_lat = 20; stub_cnt = 10; stub_gap_len = 0; stray_n = 3; stray_delay = 60;
        send_frame(0, 1'b0);
        t = 0;
        while (err_timeout !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("err_timeout_set", 32'(err_timeout), 32'd1);
        check("timeout_cycle", 32'(cyc - burst_end_cyc), 32'(LIM + 1));
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_s_ready", 32'(s_ready), 32'd1);
        check("timeout_no_frame_done", 32'(frames_done), 32'(nf));
        check("timeout_partial_drained", 32'(exp_m.size()), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_timeout_cleared", 32'(err_timeout), 32'd0);
        stub_cnt = N; stub_lat = 10; stray_n = 0;
        send_frame(2, 1'b0);
        nf++; wait_frames(nf, 500);
        check("err_after_good_frame", 32'(err_timeout), 32'd0);
`endif

        // 5: reset in the middle of a burst, then a fresh frame
        stub_cnt = N; stub_lat = 5; stub_gap_len = 0; stray_n = 0;
        send_frame(0, 1'b0);
        t = 0;
        while (run_len < 10 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("burst_reached_beat10", 32'(run_len >= 10), 32'd1);
        rst_abort = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_fft_in_valid", 32'(fft_in_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        reset = 1'b0;
        send_frame(1, 1'b0);
        nf++; wait_frames(nf, 500);

`ifndef FFT_TIMEOUT_EN
        // 6: core silent for 500 cycles after the burst
        stub_lat = 500;
        b0 = bursts_seen;
        send_frame(0, 1'b0);
        t = 0;
        while (bursts_seen == b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("silent_burst_seen", 32'(bursts_seen), 32'(b0 + 1));
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (busy !== 1'b1 || err_timeout !== 1'b0) bad++;
        end
        check("silent_busy_no_err", 32'(bad), 32'd0);
        nf++; wait_frames(nf, 300);
`endif

        repeat (10) @(negedge clk);
        check("burst_queue_drained", 32'(exp_burst.size()), 32'd0);
        check("final_result_queue", 32'(exp_m.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
